lcd_spi_cfg_scheduler: RTL and testbench

//  Sequences all writes and reads on the LCD panel's 3-wire serial configuration port.

---
 rtl/lcd_cfg_pkg.sv | 20 ++
 rtl/lcd_spi_shifter.sv | 103 ++++++++++
 rtl/lcd_spi_cfg_scheduler.sv | 174 +++++++++++++++++
 tb/tb_lcd_spi_cfg_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cfg_pkg.sv
// Shared types and constants for the LCD serial configuration scheduler.
package lcd_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    localparam int          FRAME_W         = 16;
    localparam int          RW_BIT          = 9;
    localparam logic [15:0] WAKEUP_WORD_DEF = 16'h0203;
    localparam logic [2:0]  WAKEUP_SLOT     = 3'd7;

    // A frame with the R/W bit clear asks the panel to return its data byte.
    function automatic logic is_read(input logic [FRAME_W-1:0] word);
        return ~word[RW_BIT];
    endfunction

endpackage

// File: rtl/lcd_spi_shifter.sv
// Bit-level engine for one 16-bit panel frame: SPCK divider, MSB-first shift-out
// and capture of the panel's reply byte on read frames.
module lcd_spi_shifter
    import lcd_cfg_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    input  logic               spda_in,
    output logic               spena,
    output logic               spck,
    output logic               spda_out,
    output logic               spda_oe,
    output logic               done,
    output logic               rd_valid,
    output logic [7:0]         rd_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic               active;
    logic               half;
    logic [DIV_W-1:0]   div;
    logic [3:0]         bit_idx;
    logic [3:0]         next_idx;
    logic [FRAME_W-1:0] shreg;
    logic               rd_frame;
    logic [7:0]         cap;

    // Index of the bit that follows the one currently on the wire.
    always_comb begin
        next_idx = bit_idx - 4'd1;
    end

    // Each bit spends CLK_DIV cycles with SPCK low, then CLK_DIV cycles high; the
    // divider only counts while a frame is on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            half     <= 1'b0;
            div      <= '0;
            bit_idx  <= 4'd15;
            shreg    <= '0;
            rd_frame <= 1'b0;
            cap      <= '0;
            spena    <= 1'b1;
            spck     <= 1'b1;
            spda_out <= 1'b0;
            spda_oe  <= 1'b1;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            if (!active) begin
                div <= '0;
                if (start) begin
                    active   <= 1'b1;
                    half     <= 1'b0;
                    bit_idx  <= 4'd15;
                    shreg    <= frame;
                    rd_frame <= is_read(frame);
                    spena    <= 1'b0;
                    spck     <= 1'b0;
                    spda_out <= frame[FRAME_W-1];
                    spda_oe  <= 1'b1;
                end
            end else if (div != DIV_W'(CLK_DIV - 1)) begin
                div <= div + 1'b1;
            end else begin
                div <= '0;
                if (!half) begin
                    half <= 1'b1;
                    spck <= 1'b1;
                    if (rd_frame && bit_idx <= 4'd7) begin
                        cap <= {cap[6:0], spda_in};
                    end
                end else if (bit_idx == 4'd0) begin
                    active   <= 1'b0;
                    spena    <= 1'b1;
                    spda_out <= 1'b0;
                    spda_oe  <= 1'b1;
                    done     <= 1'b1;
                    if (rd_frame) begin
                        rd_valid <= 1'b1;
                        rd_data  <= cap;
                    end
                end else begin
                    half     <= 1'b0;
                    spck     <= 1'b0;
                    bit_idx  <= next_idx;
                    spda_out <= shreg[next_idx];
                    spda_oe  <= !(rd_frame && next_idx <= 4'd7);
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_cfg_scheduler.sv
// Shares the panel's 3-wire configuration link between several configuration
// sources: wakeup frame after reset, then round-robin service of changed slots.
module lcd_spi_cfg_scheduler
    import lcd_cfg_pkg::*;
#(
    parameter int          CLK_DIV     = 16,
    parameter int          NUM_SLOTS   = 4,
    parameter int          GAP_BITS    = 16,
    parameter logic [15:0] WAKEUP_WORD = WAKEUP_WORD_DEF
) (
    input  logic                    LCLK,
    input  logic                    RST,
    input  logic [16*NUM_SLOTS-1:0] slot_word,
    input  logic                    refresh,
    output logic                    SPENA,
    output logic                    SPCK,
    output logic                    SPDA_OUT,
    output logic                    SPDA_OE,
    input  logic                    SPDA_IN,
    output logic                    busy,
    output logic [2:0]              cur_slot,
    output logic                    frame_done,
    output logic                    rd_valid,
    output logic [7:0]              rd_data
);

    localparam int GAP_CYCLES = 2 * CLK_DIV * GAP_BITS;
    localparam int GAP_W      = $clog2(GAP_CYCLES + 1);

    state_t               state;
    logic                 wake_pend;
    logic [NUM_SLOTS-1:0] pend;
    logic [NUM_SLOTS-1:0] force_req;
    logic [NUM_SLOTS-1:0] diff;
    logic [NUM_SLOTS-1:0] req;
    logic [15:0]          shadow [NUM_SLOTS];
    logic [2:0]           rr_ptr;
    logic [FRAME_W-1:0]   frame;
    logic                 start;
    logic                 done;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 grant_any;
    logic [2:0]           grant_idx;
    logic [15:0]          grant_word;
    logic                 do_grant;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NUM_SLOTS) ? s - NUM_SLOTS : s;
    endfunction

    // A slot asks for the link when pending and either its word moved away from
    // what the panel last received or a refresh forces it out again.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            diff[i] = (slot_word[16*i +: 16] != shadow[i]);
        end
        req = pend & (diff | force_req);
    end

    // Round-robin pick: the lowest offset from rr_ptr wins, so scan offsets downward.
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_word = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (req[j] && j == wrap_idx(int'(rr_ptr), k)) begin
                    grant_any  = 1'b1;
                    grant_idx  = 3'(j);
                    grant_word = slot_word[16*j +: 16];
                end
            end
        end
        do_grant = (state == ST_IDLE) && !wake_pend && grant_any;
    end

    // Pending bookkeeping; a refresh wins over the clear from a same-cycle grant.
    always_ff @(posedge LCLK) begin
        if (RST) begin
            pend      <= '1;
            force_req <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (do_grant && grant_idx == 3'(i)) begin
                    shadow[i] <= slot_word[16*i +: 16];
                end
                if (refresh) begin
                    pend[i]      <= 1'b1;
                    force_req[i] <= 1'b1;
                end else if (do_grant && grant_idx == 3'(i)) begin
                    pend[i]      <= 1'b0;
                    force_req[i] <= 1'b0;
                end else if (diff[i]) begin
                    pend[i] <= 1'b1;
                end
            end
        end
    end

    // Frame sequencing: grant in IDLE, wait for the shifter, then hold the link idle.
    always_ff @(posedge LCLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            wake_pend <= 1'b1;
            rr_ptr    <= '0;
            frame     <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            cur_slot  <= WAKEUP_SLOT;
            gap_cnt   <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wake_pend) begin
                        wake_pend <= 1'b0;
                        frame     <= WAKEUP_WORD;
                        cur_slot  <= WAKEUP_SLOT;
                        start     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end else if (grant_any) begin
                        frame    <= grant_word;
                        cur_slot <= grant_idx;
                        rr_ptr   <= (grant_idx == 3'(NUM_SLOTS - 1)) ? 3'd0 : grant_idx + 3'd1;
                        start    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (done) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    lcd_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk      (LCLK),
        .rst      (RST),
        .start    (start),
        .frame    (frame),
        .spda_in  (SPDA_IN),
        .spena    (SPENA),
        .spck     (SPCK),
        .spda_out (SPDA_OUT),
        .spda_oe  (SPDA_OE),
        .done     (done),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    assign frame_done = done;

endmodule

// File: tb/tb_lcd_spi_cfg_scheduler.sv
// Self-checking bench for lcd_spi_cfg_scheduler with a small panel model.
module tb_lcd_spi_cfg_scheduler;

    localparam int CLK_DIV   = 4;
    localparam int NUM_SLOTS = 4;
    localparam int GAP_BITS  = 2;
    localparam int FRAME_CYC = 32 * CLK_DIV;
    localparam int GAP_CYC   = 2 * CLK_DIV * GAP_BITS;
    localparam int TIMEOUT   = 2000;

    logic        lclk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] slot_word = '0;
    logic        refresh = 1'b0;
    logic        spda_in = 1'b0;
    logic        spena, spck, spda_out, spda_oe, busy, frame_done, rd_valid;
    logic [2:0]  cur_slot;
    logic [7:0]  rd_data;

    int tests_run = 0;
    int failures = 0;

    lcd_spi_cfg_scheduler #(
        .CLK_DIV   (CLK_DIV),
        .NUM_SLOTS (NUM_SLOTS),
        .GAP_BITS  (GAP_BITS)
    ) dut (
        .LCLK       (lclk),
        .RST        (rst),
        .slot_word  (slot_word),
        .refresh    (refresh),
        .SPENA      (spena),
        .SPCK       (spck),
        .SPDA_OUT   (spda_out),
        .SPDA_OE    (spda_oe),
        .SPDA_IN    (spda_in),
        .busy       (busy),
        .cur_slot   (cur_slot),
        .frame_done (frame_done),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
    );

    always #5 lclk = ~lclk;

    typedef struct {
        logic [15:0] word;
        logic [15:0] oe_bits;
        logic [2:0]  slot;
        logic        done_seen;
        logic        rdv_seen;
        logic [7:0]  rd;
        int          low_cycles;
        int          high_before;
    } frame_rec_t;

    typedef struct {
        int          slot;
        logic [15:0] word;
        logic [7:0]  panel;
        logic [7:0]  exp_rd;
    } vec_t;

    frame_rec_t  frames[$];
    logic [7:0]  panel_data = 8'h00;
    logic        prev_spena = 1'b1;
    logic        prev_spck = 1'b1;
    logic        in_frame = 1'b0;
    logic [15:0] cap_word = '0;
    logic [15:0] cap_oe = '0;
    int          bit_cnt = 0;
    int          low_cnt = 0;
    int          high_cnt = 0;
    int          cur_high = 0;

    // Panel model and frame recorder, sampling half a cycle away from the active edge.
    always @(negedge lclk) begin
        frame_rec_t r;
        if (rst) begin
            in_frame   = 1'b0;
            prev_spena = 1'b1;
            prev_spck  = 1'b1;
            high_cnt   = 0;
            spda_in    = 1'b0;
        end else begin
            if (spena == 1'b0) begin
                if (prev_spena) begin
                    in_frame = 1'b1;
                    bit_cnt  = 0;
                    low_cnt  = 0;
                    cap_word = '0;
                    cap_oe   = '0;
                    cur_high = high_cnt;
                end
                low_cnt++;
                if (!prev_spck && spck) begin
                    cap_word = {cap_word[14:0], spda_out};
                    cap_oe   = {cap_oe[14:0], spda_oe};
                    bit_cnt++;
                end
                if (!spck && bit_cnt >= 8 && bit_cnt <= 15) begin
                    spda_in = panel_data[3'(15 - bit_cnt)];
                end
            end else begin
                if (!prev_spena && in_frame) begin
                    r.word        = cap_word;
                    r.oe_bits     = cap_oe;
                    r.slot        = cur_slot;
                    r.done_seen   = frame_done;
                    r.rdv_seen    = rd_valid;
                    r.rd          = rd_data;
                    r.low_cycles  = low_cnt;
                    r.high_before = cur_high;
                    frames.push_back(r);
                    in_frame = 1'b0;
                    high_cnt = 0;
                end
                high_cnt++;
            end
            prev_spena = spena;
            prev_spck  = spck;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int slot, input logic [15:0] word);
        @(posedge lclk);
        #1;
        slot_word[16*slot +: 16] = word;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < TIMEOUT) begin
            @(posedge lclk);
            #1;
            n++;
        end
        check_output({name, " idle"}, 32'(busy), 32'd0);
    endtask

    // Waits for the next recorded frame and compares it against the expected one.
    task automatic expect_frame(input string name, input logic [15:0] word, input logic [2:0] slot,
                                input logic [7:0] exp_rd, input int min_gap);
        frame_rec_t r;
        logic       rd_frame;
        int         n = 0;
        rd_frame = ~word[9];
        while (frames.size() == 0 && n < TIMEOUT) begin
            @(posedge lclk);
            n++;
        end
        if (frames.size() == 0) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL %s: no frame seen, expected word 0x%04h", name, word);
        end else begin
            r = frames.pop_front();
            check_output({name, " word"}, 32'(r.word), 32'(word));
            check_output({name, " slot"}, 32'(r.slot), 32'(slot));
            check_output({name, " length"}, 32'(r.low_cycles), 32'(FRAME_CYC));
            check_output({name, " frame_done"}, 32'(r.done_seen), 32'd1);
            check_output({name, " oe"}, 32'(r.oe_bits), rd_frame ? 32'hFF00 : 32'hFFFF);
            check_output({name, " rd_valid"}, 32'(r.rdv_seen), 32'(rd_frame));
            check_output({name, " rd_data"}, 32'(r.rd), 32'(exp_rd));
            if (min_gap > 0) begin
                check_output({name, " gap"}, 32'(r.high_before >= min_gap), 32'd1);
            end
        end
    endtask

    vec_t vecs[5];

    initial begin
        int n;

        vecs[0] = '{slot: 1, word: 16'h2640, panel: 8'h00, exp_rd: 8'h00};
        vecs[1] = '{slot: 0, word: 16'h0500, panel: 8'hA5, exp_rd: 8'hA5};
        vecs[2] = '{slot: 2, word: 16'h2A7F, panel: 8'h00, exp_rd: 8'hA5};
        vecs[3] = '{slot: 3, word: 16'h01C3, panel: 8'h3C, exp_rd: 8'h3C};
        vecs[4] = '{slot: 1, word: 16'h2200, panel: 8'h00, exp_rd: 8'h3C};

        // Reset values
        repeat (3) @(posedge lclk);
        #1;
        check_output("reset SPENA", 32'(spena), 32'd1);
        check_output("reset SPCK", 32'(spck), 32'd1);
        check_output("reset SPDA_OUT", 32'(spda_out), 32'd0);
        check_output("reset SPDA_OE", 32'(spda_oe), 32'd1);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset cur_slot", 32'(cur_slot), 32'd7);
        check_output("reset frame_done", 32'(frame_done), 32'd0);
        check_output("reset rd_valid", 32'(rd_valid), 32'd0);
        check_output("reset rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // T1: wakeup only, since every slot word equals its cleared shadow
        expect_frame("T1 wakeup", 16'h0203, 3'd7, 8'h00, 0);
        repeat (300) @(posedge lclk);
        #1;
        check_output("T1 no slot frames", 32'(frames.size()), 32'd0);
        check_output("T1 idle", 32'(busy), 32'd0);

        // Table: one slot change at a time (T2, T4 and friends)
        for (int i = 0; i < 5; i++) begin
            panel_data = vecs[i].panel;
            apply_stimulus(vecs[i].slot, vecs[i].word);
            expect_frame($sformatf("vec%0d", i), vecs[i].word, 3'(vecs[i].slot), vecs[i].exp_rd, 0);
            wait_idle($sformatf("vec%0d", i));
            check_output($sformatf("vec%0d single frame", i), 32'(frames.size()), 32'd0);
        end

        // T3: three slots change together with rr_ptr at 2
        panel_data = 8'h00;
        @(posedge lclk);
        #1;
        slot_word[0*16 +: 16] = 16'h2301;
        slot_word[2*16 +: 16] = 16'h2302;
        slot_word[3*16 +: 16] = 16'h2303;
        expect_frame("T3 first", 16'h2302, 3'd2, 8'h3C, 0);
        expect_frame("T3 second", 16'h2303, 3'd3, 8'h3C, GAP_CYC);
        expect_frame("T3 third", 16'h2301, 3'd0, 8'h3C, GAP_CYC);
        wait_idle("T3");

        // T5: slot0 changes again while its own frame is on the wire
        apply_stimulus(0, 16'h2210);
        n = 0;
        while (spena !== 1'b0 && n < TIMEOUT) begin
            @(negedge lclk);
            n++;
        end
        check_output("T5 frame started", 32'(spena), 32'd0);
        repeat (20) @(posedge lclk);
        #1;
        slot_word[0*16 +: 16] = 16'h2218;
        expect_frame("T5 old", 16'h2210, 3'd0, 8'h3C, 0);
        expect_frame("T5 new", 16'h2218, 3'd0, 8'h3C, GAP_CYC);
        wait_idle("T5");

        // Refresh arriving mid-frame: the in-flight frame finishes, then every slot
        apply_stimulus(3, 16'h2333);
        n = 0;
        while (spena !== 1'b0 && n < TIMEOUT) begin
            @(negedge lclk);
            n++;
        end
        repeat (30) @(posedge lclk);
        #1;
        refresh = 1'b1;
        @(posedge lclk);
        #1;
        refresh = 1'b0;
        expect_frame("RF inflight", 16'h2333, 3'd3, 8'h3C, 0);
        expect_frame("RF slot0", 16'h2218, 3'd0, 8'h3C, GAP_CYC);
        expect_frame("RF slot1", 16'h2200, 3'd1, 8'h3C, GAP_CYC);
        expect_frame("RF slot2", 16'h2302, 3'd2, 8'h3C, GAP_CYC);
        expect_frame("RF slot3", 16'h2333, 3'd3, 8'h3C, GAP_CYC);
        wait_idle("RF");

        // T6: reset during bit 8 abandons the frame and restarts from wakeup
        apply_stimulus(2, 16'h2377);
        n = 0;
        while (spena !== 1'b0 && n < TIMEOUT) begin
            @(negedge lclk);
            n++;
        end
        repeat (58) @(posedge lclk);
        #1;
        rst = 1'b1;
        @(posedge lclk);
        #1;
        check_output("T6 SPENA", 32'(spena), 32'd1);
        check_output("T6 SPCK", 32'(spck), 32'd1);
        check_output("T6 busy", 32'(busy), 32'd0);
        check_output("T6 cur_slot", 32'(cur_slot), 32'd7);
        check_output("T6 rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        expect_frame("T6 wakeup", 16'h0203, 3'd7, 8'h00, 0);
        expect_frame("T6 slot0", 16'h2218, 3'd0, 8'h00, GAP_CYC);
        expect_frame("T6 slot1", 16'h2200, 3'd1, 8'h00, GAP_CYC);
        expect_frame("T6 slot2", 16'h2377, 3'd2, 8'h00, GAP_CYC);
        expect_frame("T6 slot3", 16'h2333, 3'd3, 8'h00, GAP_CYC);
        wait_idle("T6");
        repeat (100) @(posedge lclk);
        #1;
        check_output("T6 no extra frames", 32'(frames.size()), 32'd0);
        check_output("final frame_done low", 32'(frame_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
